// File: rtl/branch_pc_unit.sv
// Branch resolution and fetch-PC stage: decides taken/not-taken from the comparator
// results, computes the redirect target, owns the fetch PC and flushes IF/ID after a redirect.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC      = 32'h0000_0004,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        ex_valid,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic        beq,
    input  logic        blt,
    input  logic [31:0] pc_ex,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic        un,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        flush,
    output logic        taken,
    output logic        trap
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic        r_flush, w_flush_next;
    logic        r_taken, w_taken_next;
    logic        r_trap, w_trap_next;

    logic        w_cond;
    logic        w_resolve;
    logic        w_redirect;
    logic [31:0] w_base;
    logic [31:0] w_sum;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_advance;

    // funct3[1] selects the unsigned compare (bltu/bgeu).
    assign un        = funct3[1];
    assign link_addr = pc_ex + 32'd4;

    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:         w_cond = beq;
            3'b001:         w_cond = ~beq;
            3'b100, 3'b110: w_cond = blt;
            3'b101, 3'b111: w_cond = ~blt;
            default:        w_cond = 1'b0;
        endcase
    end

    // jalr uses rs1 as base and clears bit 0; jal and branches are pc-relative.
    assign w_base       = is_jalr ? rs1 : pc_ex;
    assign w_sum        = w_base + imm;
    assign w_target     = {w_sum[31:1], w_sum[0] & ~is_jalr};
    assign w_misaligned = w_target[1];

    assign w_resolve  = ex_valid & ~stall & (r_state == ST_RUN);
    assign w_redirect = w_resolve & (is_jalr | is_jal | (is_branch & w_cond));
    assign w_advance  = imem_ready & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= 3'd0;
            r_flush <= 1'b0;
            r_taken <= 1'b0;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
            r_flush <= w_flush_next;
            r_taken <= w_taken_next;
            r_trap  <= w_trap_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        w_flush_next = r_flush;
        w_taken_next = 1'b0;
        w_trap_next  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_flush_next = 1'b0;
                if (w_redirect) begin
                    // A redirect overrides the sequential pc+4 fetch.
                    w_pc_next    = w_misaligned ? TRAP_PC : w_target;
                    w_taken_next = 1'b1;
                    w_trap_next  = w_misaligned;
                    w_flush_next = 1'b1;
                    w_cnt_next   = FLUSH_LAST;
                    if (MULTI_FLUSH) begin
                        w_state_next = ST_FLUSH;
                    end
                end else if (w_advance) begin
                    w_pc_next = r_pc + 32'd4;
                end
            end
            ST_FLUSH: begin
                w_flush_next = 1'b1;
                if (w_advance) begin
                    w_pc_next = r_pc + 32'd4;
                end
                // The flush window counts down regardless of stall.
                if (r_cnt == 3'd0) begin
                    w_flush_next = 1'b0;
                    w_state_next = ST_RUN;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign pc    = r_pc;
    assign flush = r_flush;
    assign taken = r_taken;
    assign trap  = r_trap;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: each task drives one scenario and checks
// the registered and combinational outputs against hand-computed values.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        imem_ready;
    logic        ex_valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        beq;
    logic        blt;
    logic [31:0] pc_ex;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        un;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        flush;
    logic        taken;
    logic        trap;

    int compared;
    int mismatched;

    branch_pc_unit #(
        .RESET_PC    (32'h0000_0000),
        .TRAP_PC     (32'h0000_0004),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .imem_ready(imem_ready),
        .ex_valid  (ex_valid),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .funct3    (funct3),
        .beq       (beq),
        .blt       (blt),
        .pc_ex     (pc_ex),
        .imm       (imm),
        .rs1       (rs1),
        .un        (un),
        .pc        (pc),
        .link_addr (link_addr),
        .flush     (flush),
        .taken     (taken),
        .trap      (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%08h taken=%0b trap=%0b flush=%0b", $time, pc, taken, trap, flush);
    endtask

    task automatic clear_inputs();
        stall      = 1'b0;
        imem_ready = 1'b0;
        ex_valid   = 1'b0;
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        funct3     = 3'b000;
        beq        = 1'b0;
        blt        = 1'b0;
        pc_ex      = 32'h0;
        imm        = 32'h0;
        rs1        = 32'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %08h want %08h", pc, 32'h0); end
        compared++; if (flush !== 1'b0) begin mismatched++; $display("FAIL reset_flush got %0b want 0", flush); end
        compared++; if (taken !== 1'b0) begin mismatched++; $display("FAIL reset_taken got %0b want 0", taken); end
        compared++; if (trap !== 1'b0) begin mismatched++; $display("FAIL reset_trap got %0b want 0", trap); end
        rst = 1'b0;
        imem_ready = 1'b1;
        step();
        compared++; if (pc !== 32'h4) begin mismatched++; $display("FAIL seq_pc1 got %08h want %08h", pc, 32'h4); end
        step();
        compared++; if (pc !== 32'h8) begin mismatched++; $display("FAIL seq_pc2 got %08h want %08h", pc, 32'h8); end
        step();
        compared++; if (pc !== 32'hC) begin mismatched++; $display("FAIL seq_pc3 got %08h want %08h", pc, 32'hC); end
        compared++; if (flush !== 1'b0 || taken !== 1'b0) begin mismatched++; $display("FAIL seq_quiet got flush=%0b taken=%0b want 0/0", flush, taken); end
    endtask

    task automatic test_signed_blt();
        apply_reset();
        is_branch = 1'b1; funct3 = 3'b100; blt = 1'b1;
        pc_ex = 32'h100; imm = 32'h20; ex_valid = 1'b1;
        #1;
        compared++; if (un !== 1'b0) begin mismatched++; $display("FAIL blt_un got %0b want 0", un); end
        step();
        compared++; if (pc !== 32'h120) begin mismatched++; $display("FAIL blt_pc got %08h want %08h", pc, 32'h120); end
        compared++; if (taken !== 1'b1 || flush !== 1'b1 || trap !== 1'b0) begin mismatched++; $display("FAIL blt_flags got taken=%0b flush=%0b trap=%0b want 1/1/0", taken, flush, trap); end
        ex_valid = 1'b0;
        step();
        compared++; if (flush !== 1'b1 || taken !== 1'b0) begin mismatched++; $display("FAIL blt_flush2 got flush=%0b taken=%0b want 1/0", flush, taken); end
        step();
        compared++; if (flush !== 1'b0) begin mismatched++; $display("FAIL blt_flush_end got %0b want 0", flush); end
        funct3 = 3'b111; blt = 1'b1; ex_valid = 1'b1; imem_ready = 1'b1;
        #1;
        compared++; if (un !== 1'b1) begin mismatched++; $display("FAIL bgeu_un got %0b want 1", un); end
        step();
        compared++; if (pc !== 32'h124 || taken !== 1'b0) begin mismatched++; $display("FAIL bgeu_nt got pc=%08h taken=%0b want %08h/0", pc, taken, 32'h124); end
        // funct3 010 never branches even with both comparator results set.
        funct3 = 3'b010; beq = 1'b1; blt = 1'b1;
        step();
        compared++; if (pc !== 32'h128 || taken !== 1'b0) begin mismatched++; $display("FAIL f010_nt got pc=%08h taken=%0b want %08h/0", pc, taken, 32'h128); end
        // bne with beq=0 is taken.
        funct3 = 3'b001; beq = 1'b0; pc_ex = 32'h200; imm = 32'hFFFF_FFF0;
        step();
        compared++; if (pc !== 32'h1F0 || taken !== 1'b1) begin mismatched++; $display("FAIL bne_t got pc=%08h taken=%0b want %08h/1", pc, taken, 32'h1F0); end
    endtask

    task automatic test_jalr_align();
        apply_reset();
        is_jalr = 1'b1; pc_ex = 32'h200; rs1 = 32'h1001; imm = 32'h4; ex_valid = 1'b1;
        #1;
        compared++; if (link_addr !== 32'h204) begin mismatched++; $display("FAIL jalr_link got %08h want %08h", link_addr, 32'h204); end
        step();
        compared++; if (pc !== 32'h1004 || taken !== 1'b1 || trap !== 1'b0) begin mismatched++; $display("FAIL jalr_ok got pc=%08h taken=%0b trap=%0b want %08h/1/0", pc, taken, trap, 32'h1004); end
        ex_valid = 1'b0;
        step();
        step();
        rs1 = 32'h1002; imm = 32'h0; ex_valid = 1'b1;
        step();
        compared++; if (pc !== 32'h4 || trap !== 1'b1 || taken !== 1'b1) begin mismatched++; $display("FAIL jalr_trap got pc=%08h trap=%0b taken=%0b want %08h/1/1", pc, trap, taken, 32'h4); end
        ex_valid = 1'b0;
        step();
        compared++; if (trap !== 1'b0 || taken !== 1'b0) begin mismatched++; $display("FAIL trap_pulse got trap=%0b taken=%0b want 0/0", trap, taken); end
        step();
        // jalr outranks jal when both are flagged.
        is_jal = 1'b1; is_jalr = 1'b1; pc_ex = 32'h300; imm = 32'h10; rs1 = 32'h500; ex_valid = 1'b1;
        step();
        compared++; if (pc !== 32'h510) begin mismatched++; $display("FAIL jalr_prio got %08h want %08h", pc, 32'h510); end
    endtask

    task automatic test_stall();
        apply_reset();
        imem_ready = 1'b1; stall = 1'b1;
        is_jal = 1'b1; pc_ex = 32'h80; imm = 32'h40; ex_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (pc !== 32'h0 || taken !== 1'b0) begin mismatched++; $display("FAIL stall_hold%0d got pc=%08h taken=%0b want %08h/0", i, pc, taken, 32'h0); end
        end
        stall = 1'b0;
        step();
        compared++; if (pc !== 32'hC0 || taken !== 1'b1) begin mismatched++; $display("FAIL stall_release got pc=%08h taken=%0b want %08h/1", pc, taken, 32'hC0); end
    endtask

    task automatic test_flush_window();
        apply_reset();
        imem_ready = 1'b1;
        is_jal = 1'b1; pc_ex = 32'h400; imm = 32'h100; ex_valid = 1'b1;
        step();
        compared++; if (pc !== 32'h500 || flush !== 1'b1) begin mismatched++; $display("FAIL fw_redirect got pc=%08h flush=%0b want %08h/1", pc, flush, 32'h500); end
        pc_ex = 32'h800; imm = 32'h800;
        step();
        compared++; if (pc !== 32'h504 || taken !== 1'b0 || flush !== 1'b1) begin mismatched++; $display("FAIL fw_ignore got pc=%08h taken=%0b flush=%0b want %08h/0/1", pc, taken, flush, 32'h504); end
        rst = 1'b1;
        #1;
        compared++; if (pc !== 32'h0 || flush !== 1'b0) begin mismatched++; $display("FAIL fw_async_rst got pc=%08h flush=%0b want %08h/0", pc, flush, 32'h0); end
        ex_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        compared++; if (flush !== 1'b0 || pc !== 32'h4) begin mismatched++; $display("FAIL fw_after_rst got pc=%08h flush=%0b want %08h/0", pc, flush, 32'h4); end
    endtask

    task automatic test_wrap();
        apply_reset();
        is_branch = 1'b1; funct3 = 3'b000; beq = 1'b1;
        pc_ex = 32'hFFFF_FFF0; imm = 32'h20; ex_valid = 1'b1;
        step();
        compared++; if (pc !== 32'h10 || taken !== 1'b1 || trap !== 1'b0) begin mismatched++; $display("FAIL wrap got pc=%08h taken=%0b trap=%0b want %08h/1/0", pc, taken, trap, 32'h10); end
        ex_valid = 1'b0; pc_ex = 32'hFFFF_FFFC;
        #1;
        compared++; if (link_addr !== 32'h0) begin mismatched++; $display("FAIL link_wrap got %08h want %08h", link_addr, 32'h0); end
        step();
        step();
        // Not-taken branch with a misaligned target must not trap.
        funct3 = 3'b001; beq = 1'b1; pc_ex = 32'h40; imm = 32'h2; ex_valid = 1'b1;
        step();
        compared++; if (pc !== 32'h10 || trap !== 1'b0 || taken !== 1'b0) begin mismatched++; $display("FAIL nt_no_trap got pc=%08h trap=%0b taken=%0b want %08h/0/0", pc, trap, taken, 32'h10); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        clear_inputs();
        test_reset();
        test_signed_blt();
        test_jalr_align();
        test_stall();
        test_flush_window();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Branch-resolution and program-counter stage. Sits directly downstream of the branch comparator.
- Drives the comparator's unsigned-select and consumes its equal / less-than results, together with the EX-stage branch fields.
- Decides taken / not-taken and computes the target. Owns the fetch PC register, redirects fetch, and flushes younger pipeline stages.
- Misaligned targets are redirected to a fixed trap vector.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0004, PC loaded when a taken target is misaligned.
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (legal range 1-7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  pipeline hold; freezes the PC and blocks resolution.
- imem_ready  in  1  instruction memory accepted the current pc this cycle.
- ex_valid  in  1  EX stage holds a valid control-flow instruction.
- is_branch  in  1  EX instruction is a conditional branch.
- is_jal  in  1  EX instruction is jal.
- is_jalr  in  1  EX instruction is jalr.
- funct3  in  3  branch funct3 of the EX instruction.
- beq  in  1  comparator result: rr1 == rr2.
- blt  in  1  comparator result: rr1 < rr2 (signedness per un).
- pc_ex  in  32  PC of the EX instruction.
- imm  in  32  sign-extended immediate.
- rs1  in  32  rs1 value (jalr base).
- un  out  1  comparator unsigned-select; combinational, equals funct3[1].
- pc  out  32  fetch PC, registered.
- link_addr  out  32  pc_ex + 4, combinational, for the rd write-back.
- flush  out  1  kill IF/ID, registered.
- taken  out  1  one-cycle pulse: a redirect was applied.
- trap  out  1  one-cycle pulse: the redirect was to TRAP_PC because of misalignment.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, flush=0, taken=0, trap=0, state=RUN, flush counter=0.

Condition decode (combinational):
- funct3 000 beq; 001 !beq; 100 blt; 101 !blt; 110 blt (un=1); 111 !blt (un=1).
- funct3 010/011: cond=0 (not taken, no trap).

Resolve and target:
- resolve = ex_valid & !stall & (state==RUN).
- redirect = resolve & (is_jal | is_jalr | (is_branch & cond)).
- Target: jal/branch use pc_ex + imm. jalr uses (rs1 + imm) & ~32'h1.
- All additions are modulo 2^32; wrap-around is silent.
- misaligned = target[1] (no compressed ISA support). A not-taken branch never traps, whatever its target.
- If more than one of is_branch/is_jal/is_jalr is set: jalr takes priority, then jal, then branch.

State machine:
- RUN:
  - redirect: pc <= (misaligned ? TRAP_PC : target); taken <= 1; trap <= misaligned; flush <= 1; counter <= FLUSH_CYCLES-1; go to FLUSH if FLUSH_CYCLES > 1, else stay in RUN.
  - Otherwise, if imem_ready & !stall: pc <= pc + 4.
  - Otherwise: pc holds.
  - taken/trap are 0 in any cycle without a redirect; flush is 0 in RUN without a redirect.
- FLUSH:
  - flush = 1; ex_valid is ignored (EX is being killed).
  - pc advances by 4 on imem_ready & !stall.
  - counter decrements each cycle; stall does not pause it.
  - When counter == 0: flush <= 0, go to RUN.

Latency and hazards:
- Redirect latency is one cycle: the decision in cycle N shows as the new pc, taken and flush in cycle N+1.
- stall=1 and a redirect condition in the same cycle: no redirect, pc holds. The condition is re-evaluated once stall drops.
- imem_ready=1 and redirect in the same cycle: redirect wins; pc+4 is discarded.
- Reset mid-FLUSH: immediate return to reset values; no residual flush.

Test Plan:
- Reset: rst=1 for 2 cycles, then imem_ready=1 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0; taken=0.
- Signed vs unsigned blt: funct3=100, blt=1, pc_ex=0x100, imm=0x20, ex_valid=1 -> un=0; next cycle pc=0x120, taken=1, flush=1 for 2 cycles. Then funct3=111, blt=1 -> un=1, not taken, pc advances by 4.
- jalr alignment: is_jalr=1, rs1=0x1001, imm=0x4 -> pc=0x1004, trap=0, link_addr=pc_ex+4. Then rs1=0x1002, imm=0 -> pc=TRAP_PC (0x4), trap=1 for one cycle.
- Stall priority: is_jal=1, imm=0x40, ex_valid=1 with stall=1 for 3 cycles -> pc frozen, taken=0. Release stall -> pc=pc_ex+0x40 on the next cycle.
- Flush window: redirect, then ex_valid=1 with is_jal=1 during both FLUSH cycles -> no second redirect; flush is high exactly 2 cycles; assert rst in the 2nd flush cycle -> pc=RESET_PC and flush=0 immediately.
- Wrap-around: pc_ex=0xFFFF_FFF0, imm=0x20, beq=1, funct3=000 -> pc=0x0000_0010, taken=1, trap=0.
